// File: rtl/gray_code_counter.sv
// Gray-code up/down counter with load, clear and terminal-count pulse, plus an
// independent pipelined binary<->Gray converter channel (latency PIPE = 1 or 2).
module gray_code_counter #(
    parameter int WIDTH = 4,
    parameter int INIT  = 0,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             tc,
    input  logic             cv_in,
    input  logic             cv_mode,
    input  logic [WIDTH-1:0] cv_d,
    output logic             cv_out,
    output logic [WIDTH-1:0] cv_q
);

    localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
    // Bits below LO are resolved by the second stage when PIPE == 2.
    localparam int LO = WIDTH / 2;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] d);
        return d ^ (d >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] q;
        q = d;
        for (int i = WIDTH - 2; i >= 0; i--) q[i] = q[i+1] ^ d[i];
        return q;
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin_upper(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] q;
        q = d;
        for (int i = WIDTH - 2; i >= LO; i--) q[i] = q[i+1] ^ d[i];
        return q;
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin_lower(input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] q;
        q = p;
        for (int i = LO - 1; i >= 0; i--) q[i] = q[i+1] ^ p[i];
        return q;
    endfunction

    logic [WIDTH-1:0] b_nxt;
    logic             tc_nxt;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        b_nxt  = b;
        tc_nxt = 1'b0;
        if (clr) begin
            b_nxt = '0;
        end else if (ld) begin
            b_nxt = ld_val;
        end else if (en) begin
            if (up) begin
                b_nxt  = b + WIDTH'(1);
                tc_nxt = &b;
            end else begin
                b_nxt  = b - WIDTH'(1);
                tc_nxt = ~|b;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b  <= INIT_B;
            g  <= bin2gray(INIT_B);
            tc <= 1'b0;
        end else begin
            b  <= b_nxt;
            g  <= bin2gray(b_nxt);
            tc <= tc_nxt;
        end
    end

    generate
        if (PIPE == 1) begin : g_pipe1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cv_out <= 1'b0;
                    cv_q   <= '0;
                end else begin
                    cv_out <= cv_in;
                    if (cv_in) cv_q <= cv_mode ? gray2bin(cv_d) : bin2gray(cv_d);
                end
            end
        end else begin : g_pipe2
            logic             s1_v;
            logic             s1_mode;
            logic [WIDTH-1:0] s1_d;

            // NOTE: data stages are reset too, so a reset mid-stream can never leak a stale word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_v    <= 1'b0;
                    s1_mode <= 1'b0;
                    s1_d    <= '0;
                    cv_out  <= 1'b0;
                    cv_q    <= '0;
                end else begin
                    s1_v   <= cv_in;
                    cv_out <= s1_v;
                    if (cv_in) begin
                        s1_mode <= cv_mode;
                        s1_d    <= cv_mode ? gray2bin_upper(cv_d) : bin2gray(cv_d);
                    end
                    if (s1_v) cv_q <= s1_mode ? gray2bin_lower(s1_d) : s1_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: a 4-bit PIPE=1 instance and an 8-bit
// PIPE=2 instance (INIT=8'h3C) sharing clock and reset.
module tb_gray_code_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       a_en = 0, a_up = 1, a_ld = 0, a_clr = 0, a_cv_in = 0, a_cv_mode = 0;
    logic [3:0] a_ld_val = '0, a_cv_d = '0;
    logic [3:0] a_b, a_g, a_cv_q;
    logic       a_tc, a_cv_out;

    logic       b_en = 0, b_up = 1, b_ld = 0, b_clr = 0, b_cv_in = 0, b_cv_mode = 0;
    logic [7:0] b_ld_val = '0, b_cv_d = '0;
    logic [7:0] b_b, b_g, b_cv_q;
    logic       b_tc, b_cv_out;

    gray_code_counter #(.WIDTH(4), .INIT(0), .PIPE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .ld(a_ld), .ld_val(a_ld_val),
        .clr(a_clr), .b(a_b), .g(a_g), .tc(a_tc), .cv_in(a_cv_in), .cv_mode(a_cv_mode),
        .cv_d(a_cv_d), .cv_out(a_cv_out), .cv_q(a_cv_q)
    );

    gray_code_counter #(.WIDTH(8), .INIT(8'h3C), .PIPE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .up(b_up), .ld(b_ld), .ld_val(b_ld_val),
        .clr(b_clr), .b(b_b), .g(b_g), .tc(b_tc), .cv_in(b_cv_in), .cv_mode(b_cv_mode),
        .cv_d(b_cv_d), .cv_out(b_cv_out), .cv_q(b_cv_q)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] ref_b2g(input logic [3:0] d);
        return d ^ (d >> 1);
    endfunction

    function automatic logic [3:0] ref_g2b(input logic [3:0] d);
        return d ^ (d >> 1) ^ (d >> 2) ^ (d >> 3);
    endfunction

    int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        logic [3:0] w;
        logic       m;

        // 1. reset with en=1, then a full upward lap
        a_en = 1; a_up = 1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_a_b", a_b, 0);
        check("rst_a_g", a_g, 0);
        check("rst_a_tc", a_tc, 0);
        check("rst_b_b", b_b, 8'h3C);
        check("rst_b_g", b_g, 8'h22);
        check("rst_cv_out", a_cv_out, 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_b", a_b, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("up_g_%0d", k), a_g, gtab[k % 16]);
            check($sformatf("up_b_%0d", k), a_b, k % 16);
            check($sformatf("up_tc_%0d", k), a_tc, (k == 16) ? 1 : 0);
        end

        // 2. downward wrap from 0
        a_up = 0;
        step();
        check("dn_wrap_b", a_b, 4'hF);
        check("dn_wrap_g", a_g, 4'h8);
        check("dn_wrap_tc", a_tc, 1);
        step();
        check("dn_b", a_b, 4'hE);
        check("dn_g", a_g, 4'h9);
        check("dn_tc", a_tc, 0);

        // 3. load beats enable, clear beats load; neither raises tc
        a_ld = 1; a_ld_val = 4'd10;
        step();
        check("ld_b", a_b, 4'hA);
        check("ld_g", a_g, 4'hF);
        check("ld_tc", a_tc, 0);
        a_ld_val = 4'hF;
        step();
        check("ld_ones_b", a_b, 4'hF);
        check("ld_ones_tc", a_tc, 0);
        a_clr = 1;
        step();
        check("clr_b", a_b, 0);
        check("clr_g", a_g, 0);
        check("clr_tc", a_tc, 0);
        a_clr = 0; a_ld = 0; a_en = 0;
        step();
        check("hold_b", a_b, 0);
        check("hold_tc", a_tc, 0);

        // 4. converter, PIPE=1
        a_cv_in = 1; a_cv_mode = 0; a_cv_d = 4'd13;
        step();
        check("b2g_13_v", a_cv_out, 1);
        check("b2g_13_q", a_cv_q, 4'hB);
        a_cv_mode = 1; a_cv_d = 4'hB;
        step();
        check("g2b_B_v", a_cv_out, 1);
        check("g2b_B_q", a_cv_q, 4'd13);
        a_cv_in = 0;
        step();
        check("idle_v", a_cv_out, 0);
        check("idle_hold_q", a_cv_q, 4'd13);
        a_cv_in = 1;
        for (int i = 0; i < 32; i++) begin
            w = 4'(i);
            m = (i >= 16);
            a_cv_mode = m; a_cv_d = w;
            step();
            check($sformatf("stream_v_%0d", i), a_cv_out, 1);
            check($sformatf("stream_q_%0d", i), a_cv_q, m ? ref_g2b(w) : ref_b2g(w));
        end
        a_cv_in = 0;

        // 5. asynchronous reset mid-count with both pipes full
        a_en = 1; a_up = 1; b_en = 1; b_up = 1;
        a_cv_in = 1; a_cv_mode = 0; a_cv_d = 4'h6;
        b_cv_in = 1; b_cv_mode = 1; b_cv_d = 8'h55;
        step();
        step();
        check("pre_rst_a_b", a_b, 2);
        check("pre_rst_b_b", b_b, 8'h3E);
        check("pre_rst_b_v", b_cv_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_a_b", a_b, 0);
        check("async_a_g", a_g, 0);
        check("async_a_tc", a_tc, 0);
        check("async_a_v", a_cv_out, 0);
        check("async_b_b", b_b, 8'h3C);
        check("async_b_g", b_g, 8'h22);
        check("async_b_v", b_cv_out, 0);
        check("async_b_q", b_cv_q, 0);
        a_en = 0; b_en = 0; a_cv_in = 0; b_cv_in = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("no_stale_a_%0d", k), a_cv_out, 0);
            check($sformatf("no_stale_b_%0d", k), b_cv_out, 0);
        end
        check("post_rst_b_b", b_b, 8'h3C);

        // 6. 8-bit wrap and PIPE=2 converter
        b_ld = 1; b_ld_val = 8'hFF;
        step();
        check("w8_ld_b", b_b, 8'hFF);
        check("w8_ld_g", b_g, 8'h80);
        check("w8_ld_tc", b_tc, 0);
        b_ld = 0; b_en = 1; b_up = 1;
        step();
        check("w8_wrap_b", b_b, 8'h00);
        check("w8_wrap_tc", b_tc, 1);
        b_en = 0;
        b_cv_in = 1; b_cv_mode = 1; b_cv_d = 8'h80;
        step();
        check("p2_lat1_v", b_cv_out, 0);
        b_cv_in = 0;
        step();
        check("p2_80_v", b_cv_out, 1);
        check("p2_80_q", b_cv_q, 8'hFF);
        check("w8_tc_clear", b_tc, 0);
        b_cv_in = 1; b_cv_mode = 0; b_cv_d = 8'h5A;
        step();
        b_cv_mode = 1;
        step();
        check("p2_mix0_v", b_cv_out, 1);
        check("p2_mix0_q", b_cv_q, 8'h77);
        b_cv_in = 0;
        step();
        check("p2_mix1_v", b_cv_out, 1);
        check("p2_mix1_q", b_cv_q, 8'h6C);
        step();
        check("p2_idle_v", b_cv_out, 0);
        check("p2_idle_q", b_cv_q, 8'h6C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
